fractal_neuron_mt: RTL and testbench

Multithreaded, parametrised successor to the single-context Mandelbrot neuron. It keeps up to CTX pixel contexts in flight, interleaved round-robin through one shared 3-multiplier pipeline, so the pipeline issues one iteration per cycle instead of one per four. It adds a run-time Mandelbrot/Julia mode, a programmable escape threshold, per-pixel latched max_iter, and a result port with valid/ready backpressure. It sits between the pixel dispatcher and the result writeback, in the same slot as the earlier neuron.

---
 rtl/fractal_neuron_mt_if.sv | 39 +++
 rtl/fractal_neuron_mt.sv | 243 ++++++++++++++++++++++++
 tb/tb_fractal_neuron_mt.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fractal_neuron_mt_if.sv
// Pixel-in / result-out bundle for fractal_neuron_mt, plus its status outputs.
// The master side belongs to the dispatcher and writeback; the slave side belongs to the neuron.
interface fractal_neuron_mt_if #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 16,
    parameter int ID_W   = 16,
    parameter int CNT_W  = 3
);
    logic              pixel_valid;
    logic              pixel_ready;
    logic [WIDTH-1:0]  c_re;
    logic [WIDTH-1:0]  c_im;
    logic [ID_W-1:0]   pixel_id;
    logic [ITER_W-1:0] max_iter;
    logic              julia_mode;
    logic [WIDTH-1:0]  julia_c_re;
    logic [WIDTH-1:0]  julia_c_im;
    logic [WIDTH-1:0]  escape_thresh;
    logic              result_valid;
    logic              result_ready;
    logic [ID_W-1:0]   result_pixel_id;
    logic [ITER_W-1:0] result_iter;
    logic              busy;
    logic [CNT_W-1:0]  active_count;

    modport master (
        output pixel_valid, c_re, c_im, pixel_id, max_iter, julia_mode,
               julia_c_re, julia_c_im, escape_thresh, result_ready,
        input  pixel_ready, result_valid, result_pixel_id, result_iter,
               busy, active_count
    );

    modport slave (
        input  pixel_valid, c_re, c_im, pixel_id, max_iter, julia_mode,
               julia_c_re, julia_c_im, escape_thresh, result_ready,
        output pixel_ready, result_valid, result_pixel_id, result_iter,
               busy, active_count
    );
endinterface

// File: rtl/fractal_neuron_mt.sv
// Multithreaded Mandelbrot/Julia iterator: CTX pixel contexts are visited round-robin
// and share one pipelined bank of three fixed-point multipliers.
module fixed_mul #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 28,
    parameter int LAT   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] p
);
    logic signed [2*WIDTH-1:0] full;
    logic signed [WIDTH-1:0]   pipe [LAT];
    logic [LAT-1:0]            vpipe;
    logic                      unused_bits;

    assign full        = a * b;
    assign unused_bits = ^{full[2*WIDTH-1:FRAC+WIDTH], full[FRAC-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
            for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            vpipe[0] <= valid_in;
            pipe[0]  <= full[FRAC+WIDTH-1:FRAC];
            for (int unsigned i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                pipe[i]  <= pipe[i-1];
            end
        end
    end

    assign valid_out = vpipe[LAT-1];
    assign p         = pipe[LAT-1];
endmodule

module fractal_neuron_mt #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 28,
    parameter int ITER_W  = 16,
    parameter int ID_W    = 16,
    parameter int CTX     = 4,
    parameter int MUL_LAT = 3
) (
    input logic               clk,
    input logic               rst,
    fractal_neuron_mt_if.slave bus
);
    localparam int SLOT_W = (CTX > 1) ? $clog2(CTX) : 1;
    localparam int CNT_W  = $clog2(CTX + 1);

    typedef logic [SLOT_W-1:0] slot_t;
    typedef enum logic [1:0] {CTX_FREE, CTX_RUN, CTX_HOLD} ctx_state_t;

    // Squares must land before the owning context is visited again.
    if (CTX < MUL_LAT + 1) begin : g_ctx_check
        $error("fractal_neuron_mt: CTX must be at least MUL_LAT+1");
    end

    ctx_state_t              state      [CTX];
    logic signed [WIDTH-1:0] z_re       [CTX];
    logic signed [WIDTH-1:0] z_im       [CTX];
    logic signed [WIDTH-1:0] c_re_q     [CTX];
    logic signed [WIDTH-1:0] c_im_q     [CTX];
    logic signed [WIDTH-1:0] sq_re      [CTX];
    logic signed [WIDTH-1:0] sq_im      [CTX];
    logic signed [WIDTH-1:0] sq_x       [CTX];
    logic [ITER_W-1:0]       iter_q     [CTX];
    logic [ITER_W-1:0]       max_iter_q [CTX];
    logic [ID_W-1:0]         id_q       [CTX];
    slot_t                   slot;
    slot_t                   tag_pipe   [MUL_LAT];

    ctx_state_t              state_nxt;
    logic signed [WIDTH-1:0] z_re_nxt, z_im_nxt, c_re_nxt, c_im_nxt, mag;
    logic [ITER_W-1:0]       iter_nxt;
    logic                    accept, issue, load, escaped, done, can_load;

    logic                    res_valid;
    logic [ID_W-1:0]         res_id;
    logic [ITER_W-1:0]       res_iter;
    logic [CNT_W-1:0]        active;

    logic                    v_re, v_im, v_x;
    logic signed [WIDTH-1:0] p_re, p_im, p_x;

    always_comb begin
        state_nxt = state[slot];
        z_re_nxt  = z_re[slot];
        z_im_nxt  = z_im[slot];
        c_re_nxt  = c_re_q[slot];
        c_im_nxt  = c_im_q[slot];
        iter_nxt  = iter_q[slot];
        accept    = 1'b0;
        issue     = 1'b0;
        load      = 1'b0;
        can_load  = !res_valid || bus.result_ready;
        mag       = sq_re[slot] + sq_im[slot];
        escaped   = mag[WIDTH-1]
                  | (mag >= $signed(bus.escape_thresh))
                  | (z_re[slot][WIDTH-1] ^ z_re[slot][WIDTH-2])
                  | (z_im[slot][WIDTH-1] ^ z_im[slot][WIDTH-2]);
        done      = escaped | (iter_q[slot] >= max_iter_q[slot]);

        case (state[slot])
            CTX_FREE: begin
                if (bus.pixel_valid) begin
                    accept    = 1'b1;
                    issue     = 1'b1;
                    state_nxt = CTX_RUN;
                    iter_nxt  = '0;
                    if (bus.julia_mode) begin
                        z_re_nxt = bus.c_re;
                        z_im_nxt = bus.c_im;
                        c_re_nxt = bus.julia_c_re;
                        c_im_nxt = bus.julia_c_im;
                    end else begin
                        z_re_nxt = '0;
                        z_im_nxt = '0;
                        c_re_nxt = bus.c_re;
                        c_im_nxt = bus.c_im;
                    end
                end
            end
            CTX_RUN: begin
                if (done) begin
                    if (can_load) begin
                        load      = 1'b1;
                        state_nxt = CTX_FREE;
                    end else begin
                        state_nxt = CTX_HOLD;
                    end
                end else begin
                    z_re_nxt = sq_re[slot] - sq_im[slot] + c_re_q[slot];
                    z_im_nxt = (sq_x[slot] <<< 1) + c_im_q[slot];
                    iter_nxt = iter_q[slot] + ITER_W'(1);
                    issue    = 1'b1;
                end
            end
            CTX_HOLD: begin
                if (can_load) begin
                    load      = 1'b1;
                    state_nxt = CTX_FREE;
                end
            end
            default: state_nxt = CTX_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
            for (int unsigned i = 0; i < CTX; i++) begin
                state[i]      <= CTX_FREE;
                z_re[i]       <= '0;
                z_im[i]       <= '0;
                c_re_q[i]     <= '0;
                c_im_q[i]     <= '0;
                iter_q[i]     <= '0;
                max_iter_q[i] <= '0;
                id_q[i]       <= '0;
            end
        end else begin
            slot         <= (slot == slot_t'(CTX - 1)) ? '0 : slot + slot_t'(1);
            state[slot]  <= state_nxt;
            z_re[slot]   <= z_re_nxt;
            z_im[slot]   <= z_im_nxt;
            c_re_q[slot] <= c_re_nxt;
            c_im_q[slot] <= c_im_nxt;
            iter_q[slot] <= iter_nxt;
            if (accept) begin
                id_q[slot]       <= bus.pixel_id;
                max_iter_q[slot] <= bus.max_iter;
            end
        end
    end

    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC), .LAT(MUL_LAT)) u_mul_re (
        .clk(clk), .rst(rst), .valid_in(issue), .a(z_re_nxt), .b(z_re_nxt),
        .valid_out(v_re), .p(p_re)
    );
    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC), .LAT(MUL_LAT)) u_mul_im (
        .clk(clk), .rst(rst), .valid_in(issue), .a(z_im_nxt), .b(z_im_nxt),
        .valid_out(v_im), .p(p_im)
    );
    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC), .LAT(MUL_LAT)) u_mul_x (
        .clk(clk), .rst(rst), .valid_in(issue), .a(z_re_nxt), .b(z_im_nxt),
        .valid_out(v_x), .p(p_x)
    );

    // The context tag rides alongside the products so they land in the issuing context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
            for (int unsigned i = 0; i < CTX; i++) begin
                sq_re[i] <= '0;
                sq_im[i] <= '0;
                sq_x[i]  <= '0;
            end
        end else begin
            tag_pipe[0] <= slot;
            for (int unsigned i = 1; i < MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (v_re && v_im && v_x) begin
                sq_re[tag_pipe[MUL_LAT-1]] <= p_re;
                sq_im[tag_pipe[MUL_LAT-1]] <= p_im;
                sq_x[tag_pipe[MUL_LAT-1]]  <= p_x;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_iter  <= '0;
        end else if (load) begin
            res_valid <= 1'b1;
            res_id    <= id_q[slot];
            res_iter  <= iter_q[slot];
        end else if (bus.result_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_comb begin
        active = '0;
        for (int unsigned i = 0; i < CTX; i++) begin
            if (state[i] != CTX_FREE) active = active + CNT_W'(1);
        end
    end

    assign bus.pixel_ready     = (state[slot] == CTX_FREE) && !rst;
    assign bus.result_valid    = res_valid;
    assign bus.result_pixel_id = res_id;
    assign bus.result_iter     = res_iter;
    assign bus.active_count    = active;
    assign bus.busy            = (active != '0) || res_valid;
endmodule

// File: tb/tb_fractal_neuron_mt.sv
// Directed self-checking bench for fractal_neuron_mt at default parameters (CTX=4, Q4.28).
module tb_fractal_neuron_mt;
    localparam int WIDTH   = 32;
    localparam int FRAC    = 28;
    localparam int ITER_W  = 16;
    localparam int ID_W    = 16;
    localparam int CTX     = 4;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = $clog2(CTX + 1);

    localparam logic [31:0] C_2P0  = 32'h2000_0000;
    localparam logic [31:0] C_M2P0 = 32'hE000_0000;
    localparam logic [31:0] C_0P25 = 32'h0400_0000;
    localparam logic [31:0] C_1P5  = 32'h1800_0000;
    localparam logic [31:0] C_0P5  = 32'h0800_0000;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fractal_neuron_mt_if #(.WIDTH(WIDTH), .ITER_W(ITER_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    fractal_neuron_mt #(
        .WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W), .ID_W(ID_W),
        .CTX(CTX), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pixel(input logic [31:0] cr, input logic [ID_W-1:0] id,
                             input logic [ITER_W-1:0] mi, input logic jm);
        bus.c_re       = cr;
        bus.c_im       = '0;
        bus.pixel_id   = id;
        bus.max_iter   = mi;
        bus.julia_mode = jm;
        bus.julia_c_re = '0;
        bus.julia_c_im = '0;
    endtask

    // Returns the cycle count right after the accepting edge.
    task automatic offer(input logic [31:0] cr, input logic [ID_W-1:0] id,
                         input logic [ITER_W-1:0] mi, input logic jm, output int t_acc);
        int budget;
        set_pixel(cr, id, mi, jm);
        bus.pixel_valid = 1'b1;
        budget = 100;
        while (!bus.pixel_ready && budget > 0) begin
            step();
            budget--;
        end
        check_eq("accept_ready", 64'(bus.pixel_ready), 64'd1);
        @(posedge clk);
        #1;
        t_acc = cyc;
        bus.pixel_valid = 1'b0;
    endtask

    task automatic wait_result(input int budget, output logic [ID_W-1:0] id,
                               output logic [ITER_W-1:0] it, output int t_seen);
        bit seen;
        seen   = 1'b0;
        t_seen = -1;
        id     = '0;
        it     = '0;
        while (!seen && budget > 0) begin
            step();
            budget--;
            if (bus.result_valid) begin
                seen   = 1'b1;
                id     = bus.result_pixel_id;
                it     = bus.result_iter;
                t_seen = cyc;
            end
        end
        check_eq("result_seen", 64'(seen), 64'd1);
    endtask

    // A pixel finishing with count n is loaded at edge t+(n+1)*CTX, visible in cycle t+(n+1)*CTX+1.
    task automatic run_single(input string tag, input logic [31:0] cr, input logic jm,
                              input logic [ID_W-1:0] id, input logic [ITER_W-1:0] mi,
                              input int exp_iter, input int budget);
        int                t_acc, t_seen;
        logic [ID_W-1:0]   rid;
        logic [ITER_W-1:0] rit;
        offer(cr, id, mi, jm, t_acc);
        wait_result(budget, rid, rit, t_seen);
        check_eq({tag, "_id"}, 64'(rid), 64'(id));
        check_eq({tag, "_iter"}, 64'(rit), 64'(exp_iter));
        check_eq({tag, "_lat"}, 64'(t_seen - t_acc), 64'((exp_iter + 1) * CTX));
        step();
        check_eq({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic burst(input logic [31:0] cv [4], input logic [ID_W-1:0] base_id,
                         input logic [ITER_W-1:0] mi, output int t_first);
        int budget;
        bus.pixel_valid = 1'b1;
        set_pixel(cv[0], base_id, mi, 1'b0);
        budget = 100;
        while (!bus.pixel_ready && budget > 0) begin
            step();
            budget--;
        end
        t_first = 0;
        for (int i = 0; i < 4; i++) begin
            set_pixel(cv[i], base_id + ID_W'(i), mi, 1'b0);
            check_eq("burst_ready", 64'(bus.pixel_ready), 64'd1);
            @(posedge clk);
            #1;
            if (i == 0) t_first = cyc;
            else check_eq("burst_consecutive", 64'(cyc - t_first), 64'(i));
        end
        set_pixel(cv[0], base_id + ID_W'(4), mi, 1'b0);
        check_eq("fifth_offer_ready", 64'(bus.pixel_ready), 64'd0);
        bus.pixel_valid = 1'b0;
    endtask

    initial begin
        logic [31:0]       cv [4];
        logic [ID_W-1:0]   rid;
        logic [ITER_W-1:0] rit;
        int                t0, ts, seen_cnt [4], stale, tmp;
        bit                stable;

        rst               = 1'b1;
        bus.pixel_valid   = 1'b0;
        bus.result_ready  = 1'b1;
        bus.escape_thresh = 32'h4000_0000;
        set_pixel('0, '0, '0, 1'b0);
        repeat (3) step();

        check_eq("rst_pixel_ready", 64'(bus.pixel_ready), 64'd0);
        check_eq("rst_result_valid", 64'(bus.result_valid), 64'd0);
        check_eq("rst_result_id", 64'(bus.result_pixel_id), 64'd0);
        check_eq("rst_result_iter", 64'(bus.result_iter), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_active", 64'(bus.active_count), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(bus.pixel_ready), 64'd1);

        run_single("mb_c2",      C_2P0, 1'b0, 16'h00A1, 16'd100, 1,   200);
        run_single("mb_c0_m20",  '0,    1'b0, 16'h00A2, 16'd20,  20,  400);
        run_single("mb_c0_m0",   '0,    1'b0, 16'h00A3, 16'd0,   0,   100);
        run_single("julia_1p5",  C_1P5, 1'b1, 16'h00A4, 16'd100, 1,   200);
        run_single("julia_0p5",  C_0P5, 1'b1, 16'h00A5, 16'd100, 100, 1000);

        // c = 2.0 and -2.0 escape after one iteration; 0 and 0.25 stay bounded.
        cv = '{C_2P0, 32'h0, C_M2P0, C_0P25};
        burst(cv, '0, 16'd20, t0);
        seen_cnt = '{0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            wait_result(400, rid, rit, ts);
            check_eq("b2b_id_range", 64'(rid < 4), 64'd1);
            if (rid < 4) begin
                seen_cnt[rid]++;
                check_eq("b2b_iter", 64'(rit), (rid[0] == 1'b0) ? 64'd1 : 64'd20);
            end
        end
        for (int k = 0; k < 4; k++) check_eq("b2b_once", 64'(seen_cnt[k]), 64'd1);
        step();
        check_eq("b2b_idle", 64'(bus.busy), 64'd0);

        // All four escape; the sink stalls so only the first is presented.
        bus.result_ready = 1'b0;
        cv = '{C_2P0, C_2P0, C_2P0, C_2P0};
        burst(cv, 16'd10, 16'd100, t0);
        wait_result(200, rid, rit, ts);
        check_eq("bp_first_id", 64'(rid), 64'd10);
        stable = 1'b1;
        repeat (40) begin
            step();
            if (!bus.result_valid || bus.result_pixel_id != 16'd10 || bus.result_iter != 16'd1)
                stable = 1'b0;
        end
        check_eq("bp_stable", 64'(stable), 64'd1);
        check_eq("bp_busy", 64'(bus.busy), 64'd1);
        check_eq("bp_active", 64'(bus.active_count), 64'd3);
        bus.result_ready = 1'b1;
        seen_cnt = '{0, 0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            wait_result(2 * CTX, rid, rit, ts);
            check_eq("bp_drain_range", 64'(rid >= 11 && rid <= 13), 64'd1);
            check_eq("bp_drain_iter", 64'(rit), 64'd1);
            if (rid >= 11 && rid <= 13) seen_cnt[rid - 10]++;
        end
        for (int k = 1; k < 4; k++) check_eq("bp_drain_once", 64'(seen_cnt[k]), 64'd1);
        step();
        check_eq("bp_idle", 64'(bus.busy), 64'd0);

        // Reset with three long-running pixels in flight.
        offer('0, 16'd20, 16'd100, 1'b0, tmp);
        offer('0, 16'd21, 16'd100, 1'b0, tmp);
        offer('0, 16'd22, 16'd100, 1'b0, tmp);
        repeat (10) step();
        check_eq("mid_active_before", 64'(bus.active_count), 64'd3);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(bus.result_valid), 64'd0);
        check_eq("mid_rst_active", 64'(bus.active_count), 64'd0);
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst_ready", 64'(bus.pixel_ready), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        #1;
        run_single("after_rst", C_2P0, 1'b0, 16'd77, 16'd100, 1, 200);
        stale = 0;
        repeat (60) begin
            step();
            if (bus.result_valid) stale++;
        end
        check_eq("no_stale", 64'(stale), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
